// File: rtl/cmov_seq_ctrl_if.sv
// Decode-side request/status and register-file port of the MOVE/CMOV sequencer.
// The master side is the decode stage plus the register file; the sequencer is the slave.
interface cmov_seq_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [5:0]        opcode;
  logic [ADDR_W-1:0] rs_addr;
  logic [ADDR_W-1:0] rt_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rf_raddr;
  logic [DATA_W-1:0] rf_rdata;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              busy;
  logic              done;
  logic              taken;
  logic              illegal;

  modport master (
    output start, opcode, rs_addr, rt_addr, rd_addr, rf_rdata,
    input  rf_raddr, rf_we, rf_waddr, rf_wdata, busy, done, taken, illegal
  );

  modport slave (
    input  start, opcode, rs_addr, rt_addr, rd_addr, rf_rdata,
    output rf_raddr, rf_we, rf_waddr, rf_wdata, busy, done, taken, illegal
  );
endinterface

// File: rtl/cmov_seq_ctrl.sv
// MOVE/CMOV sequencer: reads rs then rt over one RF read port, writes rs to rd if the condition holds.
// Optional CMOV_FAST_MOVE_EN: MOVE skips the rt read and completes one cycle earlier.
module cmov_seq_ctrl #(
  parameter int         DATA_W  = 32,
  parameter int         ADDR_W  = 5,
  parameter logic [5:0] OP_MOVE = 6'b110000,
  parameter logic [5:0] OP_CMOV = 6'b110001
) (
  input  logic           clk,
  input  logic           rst_n,
  cmov_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_RS = 3'd1,
    RD_RT = 3'd2,
    EVAL  = 3'd3,
    WB    = 3'd4
  } state_t;

  state_t            state;
  logic              is_cmov;
  logic [ADDR_W-1:0] rt_q;
  logic [ADDR_W-1:0] rd_q;
  logic [DATA_W-1:0] rs_val;

  logic              busy_q, done_q, taken_q, illegal_q, we_q;
  logic [ADDR_W-1:0] raddr_q, waddr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              op_legal;
  logic              rs_lt_rt;
  logic              fast_move;
  logic              cond;
  logic [DATA_W-1:0] rs_eval;

  assign op_legal = (bus.opcode == OP_MOVE) || (bus.opcode == OP_CMOV);

  // rt data is consumed straight off the read port in EVAL rather than parked in a register.
  assign rs_lt_rt = $signed(rs_val) < $signed(bus.rf_rdata);

`ifdef CMOV_FAST_MOVE_EN
  assign fast_move = ~is_cmov;
`else
  assign fast_move = 1'b0;
`endif

  // On the fast MOVE path the rs data arrives in EVAL, so it bypasses rs_val.
  assign rs_eval = fast_move ? bus.rf_rdata : rs_val;
  assign cond    = ~is_cmov | rs_lt_rt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      is_cmov   <= 1'b0;
      rt_q      <= '0;
      rd_q      <= '0;
      rs_val    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      taken_q   <= 1'b0;
      illegal_q <= 1'b0;
      we_q      <= 1'b0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (op_legal) begin
              is_cmov <= (bus.opcode == OP_CMOV);
              rt_q    <= bus.rt_addr;
              rd_q    <= bus.rd_addr;
              raddr_q <= bus.rs_addr;
              state   <= RD_RS;
            end else begin
              // Illegal opcode: complete at once with no register traffic.
              done_q    <= 1'b1;
              illegal_q <= 1'b1;
              taken_q   <= 1'b0;
              we_q      <= 1'b0;
              waddr_q   <= '0;
              wdata_q   <= '0;
              state     <= WB;
            end
          end
        end

        RD_RS: begin
          if (fast_move) begin
            raddr_q <= '0;
            state   <= EVAL;
          end else begin
            raddr_q <= rt_q;
            state   <= RD_RT;
          end
        end

        RD_RT: begin
          rs_val  <= bus.rf_rdata;
          raddr_q <= '0;
          state   <= EVAL;
        end

        EVAL: begin
          rs_val    <= rs_eval;
          done_q    <= 1'b1;
          taken_q   <= cond;
          illegal_q <= 1'b0;
          we_q      <= cond;
          waddr_q   <= rd_q;
          wdata_q   <= rs_eval;
          state     <= WB;
        end

        WB: begin
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          taken_q   <= 1'b0;
          illegal_q <= 1'b0;
          we_q      <= 1'b0;
          waddr_q   <= '0;
          wdata_q   <= '0;
          state     <= IDLE;
        end

        default: begin
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
          taken_q   <= 1'b0;
          illegal_q <= 1'b0;
          we_q      <= 1'b0;
          raddr_q   <= '0;
          waddr_q   <= '0;
          wdata_q   <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.taken    = taken_q;
  assign bus.illegal  = illegal_q;
  assign bus.rf_we    = we_q;
  assign bus.rf_raddr = raddr_q;
  assign bus.rf_waddr = waddr_q;
  assign bus.rf_wdata = wdata_q;

endmodule
